race_starter: RTL and testbench

Initiator end of the start/done race handshake. Raises `start`, waits for the responder's `done`, drops `start`, waits for `done` to fall, then repeats for a fixed number of rounds. It measures each round's response latency and flags a responder that hangs. It sits opposite a `done`-producing responder in the handshaking lab and drives that responder's `start` input directly.

---
 rtl/race_starter.sv | 178 +++++++++++++++++
 tb/tb_race_starter.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/race_starter.sv
// Initiator side of the start/done race handshake: runs ROUNDS request/release
// rounds, records per-round latency and flags a responder that stops answering.
module race_starter #(
  parameter int ROUNDS  = 4,
  parameter int TIMEOUT = 200,
  parameter int GAP     = 2,
  parameter int LAT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             go,
  input  logic             done,
  output logic             start,
  output logic             busy,
  output logic             finished,
  output logic             timeout_err,
  output logic [7:0]       round_cnt,
  output logic [LAT_W-1:0] last_lat,
  output logic [LAT_W-1:0] max_lat
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_REL  = 3'd2,
    S_GAP  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [LAT_W-1:0] TIMEOUT_L = LAT_W'(TIMEOUT);
  localparam logic [7:0]       ROUNDS_L  = 8'(ROUNDS);
  localparam logic [3:0]       GAP_LAST  = 4'(GAP - 1);

  state_t           state_reg, state_next;
  logic             start_reg, start_next;
  logic             busy_reg, busy_next;
  logic             finished_reg, finished_next;
  logic             err_reg, err_next;
  logic [7:0]       round_reg, round_next;
  logic [LAT_W-1:0] last_lat_reg, last_lat_next;
  logic [LAT_W-1:0] max_lat_reg, max_lat_next;
  // lat_cnt doubles as the stuck-high wait counter while in REL
  logic [LAT_W-1:0] lat_cnt_reg, lat_cnt_next;
  logic [3:0]       gap_cnt_reg, gap_cnt_next;

  logic [LAT_W-1:0] lat_inc;
  logic [7:0]       round_inc;

  assign lat_inc   = lat_cnt_reg + 1'b1;
  assign round_inc = round_reg + 8'd1;

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_reg    <= S_IDLE;
      start_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      finished_reg <= 1'b0;
      err_reg      <= 1'b0;
      round_reg    <= '0;
      last_lat_reg <= '0;
      max_lat_reg  <= '0;
      lat_cnt_reg  <= '0;
      gap_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      start_reg    <= start_next;
      busy_reg     <= busy_next;
      finished_reg <= finished_next;
      err_reg      <= err_next;
      round_reg    <= round_next;
      last_lat_reg <= last_lat_next;
      max_lat_reg  <= max_lat_next;
      lat_cnt_reg  <= lat_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    start_next    = start_reg;
    busy_next     = busy_reg;
    finished_next = 1'b0;
    err_next      = err_reg;
    round_next    = round_reg;
    last_lat_next = last_lat_reg;
    max_lat_next  = max_lat_reg;
    lat_cnt_next  = lat_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;

    case (state_reg)
      S_IDLE, S_ERR: begin
        if (go) begin
          state_next   = S_REQ;
          start_next   = 1'b1;
          busy_next    = 1'b1;
          err_next     = 1'b0;
          round_next   = '0;
          max_lat_next = '0;
          lat_cnt_next = '0;
          gap_cnt_next = '0;
        end
      end

      S_REQ: begin
        // done is checked first so a response on the timeout edge still counts
        if (done) begin
          last_lat_next = lat_inc;
          if (lat_inc > max_lat_reg) max_lat_next = lat_inc;
          start_next    = 1'b0;
          lat_cnt_next  = '0;
          state_next    = S_REL;
        end else if (lat_inc == TIMEOUT_L) begin
          state_next   = S_ERR;
          start_next   = 1'b0;
          busy_next    = 1'b0;
          err_next     = 1'b1;
          lat_cnt_next = '0;
        end else begin
          lat_cnt_next = lat_inc;
        end
      end

      S_REL: begin
        if (!done) begin
          round_next   = round_inc;
          lat_cnt_next = '0;
          if (round_inc == ROUNDS_L) begin
            state_next    = S_IDLE;
            busy_next     = 1'b0;
            finished_next = 1'b1;
          end else if (GAP == 0) begin
            state_next = S_REQ;
            start_next = 1'b1;
          end else begin
            state_next   = S_GAP;
            gap_cnt_next = '0;
          end
        end else if (lat_inc == TIMEOUT_L) begin
          state_next   = S_ERR;
          busy_next    = 1'b0;
          err_next     = 1'b1;
          lat_cnt_next = '0;
        end else begin
          lat_cnt_next = lat_inc;
        end
      end

      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next   = S_REQ;
          start_next   = 1'b1;
          lat_cnt_next = '0;
          gap_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end

      default: begin
        state_next    = S_IDLE;
        start_next    = 1'b0;
        busy_next     = 1'b0;
        finished_next = 1'b0;
        lat_cnt_next  = '0;
        gap_cnt_next  = '0;
      end
    endcase
  end

  assign start       = start_reg;
  assign busy        = busy_reg;
  assign finished    = finished_reg;
  assign timeout_err = err_reg;
  assign round_cnt   = round_reg;
  assign last_lat    = last_lat_reg;
  assign max_lat     = max_lat_reg;

endmodule

// File: tb/tb_race_starter.sv
// Bench for race_starter: a programmable responder plus a negedge monitor that
// checks pulse widths, gaps and final results against queued expectations.
module tb_race_starter;

  localparam int ROUNDS  = 4;
  localparam int TIMEOUT = 10;
  localparam int GAP     = 2;
  localparam int LAT_W   = 8;

  logic             clk = 1'b0;
  logic             rst_l = 1'b0;
  logic             go = 1'b0;
  logic             done = 1'b0;
  logic             start, busy, finished, timeout_err;
  logic [7:0]       round_cnt;
  logic [LAT_W-1:0] last_lat, max_lat;

  always #5 clk = ~clk;

  race_starter #(
    .ROUNDS (ROUNDS),
    .TIMEOUT(TIMEOUT),
    .GAP    (GAP),
    .LAT_W  (LAT_W)
  ) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .go         (go),
    .done       (done),
    .start      (start),
    .busy       (busy),
    .finished   (finished),
    .timeout_err(timeout_err),
    .round_cnt  (round_cnt),
    .last_lat   (last_lat),
    .max_lat    (max_lat)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    $display("check %-12s got %0d expected %0d", tag, got, exp);
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Responder: raises done on the resp_lat-th edge of start being high,
  // drops it resp_rel edges after start falls (0 = never).
  int         resp_lat[4];
  int         resp_rel = 1;
  logic [1:0] resp_idx = 2'd0;
  bit         resp_kill = 1'b0;
  int         hi_r = 0;
  int         lo_r = 0;

  always @(negedge clk) begin
    if (!rst_l || resp_kill) begin
      done = 1'b0;
      hi_r = 0;
      lo_r = 0;
    end else if (start) begin
      lo_r = 0;
      hi_r++;
      if (resp_lat[resp_idx] != 0 && hi_r == resp_lat[resp_idx]) done = 1'b1;
    end else begin
      hi_r = 0;
      if (done) begin
        lo_r++;
        if (resp_rel != 0 && lo_r == resp_rel) begin
          done = 1'b0;
          resp_idx++;
        end
      end
    end
  end

  typedef struct {
    int rc;
    int mx;
    int ll;
  } fin_t;

  int   lat_q[$];
  int   gap_q[$];
  fin_t fin_q[$];

  logic start_p = 1'b0, fin_p = 1'b0, err_p = 1'b0;
  int   hi_c = 0, lo_c = 0, pulses = 0, fin_cnt = 0, err_hi = 0, err_lo = 0;

  // Monitor: hi_c/lo_c count earlier negedges of the current high/low phase
  always @(negedge clk) begin
    if (!rst_l) begin
      start_p = 1'b0;
      fin_p   = 1'b0;
      err_p   = 1'b0;
      hi_c    = 0;
      lo_c    = 0;
      pulses  = 0;
    end else begin
      if (!busy && !start) pulses = 0;
      if (start && !start_p) begin
        if (pulses > 0) begin
          if (gap_q.size() == 0) chk("gap_q_size", gap_q.size(), 1);
          else chk("gap_low", lo_c, gap_q.pop_front());
        end
        pulses++;
      end
      if (!start && start_p && !timeout_err) begin
        if (lat_q.size() == 0) chk("lat_q_size", lat_q.size(), 1);
        else begin
          int e;
          e = lat_q.pop_front();
          chk("last_lat", last_lat, e);
          chk("start_width", hi_c, e);
        end
      end
      if (timeout_err && !err_p) begin
        err_hi = hi_c;
        err_lo = lo_c;
      end
      if (finished) begin
        if (fin_q.size() == 0) chk("fin_q_size", fin_q.size(), 1);
        else begin
          fin_t f;
          f = fin_q.pop_front();
          chk("fin_rounds", round_cnt, f.rc);
          chk("fin_max", max_lat, f.mx);
          chk("fin_last", last_lat, f.ll);
          chk("fin_busy", busy, 0);
        end
        fin_cnt++;
      end
      if (fin_p) chk("fin_pulse", finished, 0);
      if (start) begin
        if (!start_p) hi_c = 0;
        hi_c++;
      end else begin
        if (start_p) lo_c = 0;
        lo_c++;
      end
      start_p = start;
      fin_p   = finished;
      err_p   = timeout_err;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick(1);
    go = 1'b0;
  endtask

  task automatic wait_fin(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (fin_cnt >= target) break;
      @(negedge clk);
    end
    chk("fin_seen", fin_cnt, target);
    tick(1);
  endtask

  task automatic wait_err(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (timeout_err === 1'b1) break;
      @(negedge clk);
    end
    chk("err_seen", timeout_err, 1);
    tick(1);
  endtask

  task automatic run_seq(input int l0, input int l1, input int l2, input int l3, input int rel);
    fin_t f;
    int   mx;
    resp_lat[0] = l0; resp_lat[1] = l1; resp_lat[2] = l2; resp_lat[3] = l3;
    resp_rel = rel;
    resp_idx = 2'd0;
    mx = 0;
    for (int i = 0; i < 4; i++) begin
      lat_q.push_back(resp_lat[i]);
      if (resp_lat[i] > mx) mx = resp_lat[i];
      if (i > 0) gap_q.push_back(rel + GAP);
    end
    f.rc = ROUNDS; f.mx = mx; f.ll = l3;
    fin_q.push_back(f);
    pulse_go();
    chk("acc_start", start, 1);
    chk("acc_busy", busy, 1);
    chk("acc_err", timeout_err, 0);
    wait_fin(fin_cnt + 1, 300);
    chk("end_busy", busy, 0);
    chk("end_err", timeout_err, 0);
  endtask

  initial begin
    resp_lat = '{0, 0, 0, 0};
    tick(3);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fin", finished, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_rounds", round_cnt, 0);
    chk("rst_last", last_lat, 0);
    chk("rst_max", max_lat, 0);
    rst_l = 1'b1;
    tick(2);

    // fixed latency 3, done falls one edge after start
    run_seq(3, 3, 3, 3, 1);
    // mixed latencies, slower release
    run_seq(2, 7, 4, 5, 2);

    // responder never answers
    resp_lat = '{0, 0, 0, 0};
    resp_idx = 2'd0;
    pulse_go();
    wait_err(60);
    chk("to_width", err_hi, TIMEOUT);
    chk("to_start", start, 0);
    chk("to_busy", busy, 0);
    chk("to_rounds", round_cnt, 0);
    run_seq(4, 4, 4, 4, 1);

    // done stuck high after round 1; go pulses in REQ and REL are ignored
    resp_lat = '{3, 3, 3, 3};
    resp_rel = 0;
    resp_idx = 2'd0;
    lat_q.push_back(3);
    pulse_go();
    pulse_go();
    for (int i = 0; i < 40; i++) begin
      if (!start && done) break;
      tick(1);
    end
    chk("stuck_done", done, 1);
    pulse_go();
    wait_err(60);
    chk("stuck_wait", err_lo, TIMEOUT);
    chk("stuck_rounds", round_cnt, 0);
    chk("stuck_busy", busy, 0);
    chk("stuck_last", last_lat, 3);
    resp_kill = 1'b1;
    tick(2);
    resp_kill = 1'b0;

    // response exactly on the timeout edge wins; started from ERR
    run_seq(TIMEOUT, TIMEOUT, TIMEOUT, TIMEOUT, 1);

    // asynchronous reset in the middle of REQ
    resp_lat = '{5, 5, 5, 5};
    resp_rel = 1;
    resp_idx = 2'd0;
    pulse_go();
    chk("pre_rst_start", start, 1);
    #2 rst_l = 1'b0;
    #1;
    chk("arst_start", start, 0);
    chk("arst_busy", busy, 0);
    tick(2);
    rst_l = 1'b1;
    tick(1);
    chk("rel_start", start, 0);
    chk("rel_busy", busy, 0);
    chk("rel_fin", finished, 0);
    chk("rel_err", timeout_err, 0);
    chk("rel_rounds", round_cnt, 0);
    chk("rel_last", last_lat, 0);
    chk("rel_max", max_lat, 0);

    chk("lat_q_left", lat_q.size(), 0);
    chk("gap_q_left", gap_q.size(), 0);
    chk("fin_q_left", fin_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
